// File: rtl/eth_rx_frame_fifo.sv
// Store-and-forward AXI-Stream frame FIFO behind the 10G MAC RX port.
// Only complete frames are published downstream; bad and overflowing frames are rolled back and counted.
//
// Write FSM
//   state    | meaning
//   ST_SYNC  | after reset: discard a frame cut by reset release, exit on its tlast or an idle cycle
//   ST_IDLE  | between frames; a valid beat starts a new frame
//   ST_FRAME | frame in progress, beats written at wr_ptr
//   ST_DROP  | frame overflowed; discard beats until tlast
module eth_rx_frame_fifo #(
    parameter int DATA_W   = 64,
    parameter int KEEP_W   = DATA_W / 8,
    parameter int DEPTH    = 512,
    parameter bit DROP_BAD = 1'b1,
    parameter int CNT_W    = 32
) (
    input  logic                     clk156,
    input  logic                     sys_rst_n,
    input  logic                     s_axis_tvalid,
    input  logic [DATA_W-1:0]        s_axis_tdata,
    input  logic [KEEP_W-1:0]        s_axis_tkeep,
    input  logic                     s_axis_tlast,
    input  logic                     s_axis_tuser,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [DATA_W-1:0]        m_axis_tdata,
    output logic [KEEP_W-1:0]        m_axis_tkeep,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tuser,
    output logic [CNT_W-1:0]         drop_bad_cnt,
    output logic [CNT_W-1:0]         drop_ovf_cnt,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam int MEM_W  = DATA_W + KEEP_W + 2;

    typedef enum logic [1:0] {ST_SYNC, ST_IDLE, ST_FRAME, ST_DROP} wr_state_t;

    logic [1:0]        r_rst_sync;
    logic              w_rst_n;
    wr_state_t         r_state;
    wr_state_t         w_state_nxt;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_wr_commit;
    logic [PTR_W-1:0]  r_commit_vis;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [MEM_W-1:0]  r_mem [DEPTH];
    logic [MEM_W-1:0]  w_rd_word;
    logic              w_full;
    logic              w_empty;
    logic              w_load;
    logic              w_wr;
    logic              w_commit;
    logic              w_rollback;
    logic              w_bad_inc;
    logic              w_ovf_inc;
    logic              r_m_valid;
    logic [DATA_W-1:0] r_m_data;
    logic [KEEP_W-1:0] r_m_keep;
    logic              r_m_last;
    logic              r_m_user;
    logic [CNT_W-1:0]  r_drop_bad;
    logic [CNT_W-1:0]  r_drop_ovf;

    // Reset asserts immediately, releases two clk156 edges after sys_rst_n rises.
    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) r_rst_sync <= 2'b00;
        else            r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_full  = (r_wr_ptr - r_rd_ptr) == PTR_W'(DEPTH);
    assign w_empty = (r_rd_ptr == r_commit_vis);

    always_ff @(posedge clk156 or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= ST_SYNC;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_commit    = 1'b0;
        w_rollback  = 1'b0;
        w_bad_inc   = 1'b0;
        w_ovf_inc   = 1'b0;
        case (r_state)
            // The MAC never gaps inside a frame, so an idle cycle proves we are between frames.
            ST_SYNC: begin
                if (!s_axis_tvalid) begin
                    w_state_nxt = ST_IDLE;
                end else if (s_axis_tlast) begin
                    w_ovf_inc   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE, ST_FRAME: begin
                if (s_axis_tvalid) begin
                    if (w_full) begin
                        w_ovf_inc   = 1'b1;
                        w_rollback  = 1'b1;
                        w_state_nxt = s_axis_tlast ? ST_IDLE : ST_DROP;
                    end else begin
                        w_wr = 1'b1;
                        if (s_axis_tlast) begin
                            w_state_nxt = ST_IDLE;
                            if (s_axis_tuser && DROP_BAD) begin
                                w_rollback = 1'b1;
                                w_bad_inc  = 1'b1;
                            end else begin
                                w_commit = 1'b1;
                            end
                        end else begin
                            w_state_nxt = ST_FRAME;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (s_axis_tvalid && s_axis_tlast) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_SYNC;
        endcase
    end

    always_ff @(posedge clk156) begin
        if (w_wr) r_mem[r_wr_ptr[ADDR_W-1:0]] <= {s_axis_tuser & s_axis_tlast, s_axis_tlast,
                                                  s_axis_tkeep, s_axis_tdata};
    end

    // r_commit_vis publishes a commit to the read side one cycle later, fixing frame latency at two edges.
    always_ff @(posedge clk156 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr_ptr     <= '0;
            r_wr_commit  <= '0;
            r_commit_vis <= '0;
            r_drop_bad   <= '0;
            r_drop_ovf   <= '0;
        end else begin
            r_commit_vis <= r_wr_commit;
            if (w_rollback)  r_wr_ptr <= r_wr_commit;
            else if (w_wr)   r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_commit)    r_wr_commit <= r_wr_ptr + PTR_W'(1);
            if (w_bad_inc && (r_drop_bad != '1)) r_drop_bad <= r_drop_bad + CNT_W'(1);
            if (w_ovf_inc && (r_drop_ovf != '1)) r_drop_ovf <= r_drop_ovf + CNT_W'(1);
        end
    end

    assign w_rd_word = r_mem[r_rd_ptr[ADDR_W-1:0]];
    assign w_load    = (!r_m_valid || m_axis_tready) && !w_empty;

    always_ff @(posedge clk156 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rd_ptr  <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_keep  <= '0;
            r_m_last  <= 1'b0;
            r_m_user  <= 1'b0;
        end else if (w_load) begin
            r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
            r_m_valid <= 1'b1;
            r_m_data  <= w_rd_word[DATA_W-1:0];
            r_m_keep  <= w_rd_word[DATA_W +: KEEP_W];
            r_m_last  <= w_rd_word[MEM_W-2];
            r_m_user  <= w_rd_word[MEM_W-1] & !DROP_BAD;
        end else if (m_axis_tready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign m_axis_tvalid = r_m_valid;
    assign m_axis_tdata  = r_m_data;
    assign m_axis_tkeep  = r_m_keep;
    assign m_axis_tlast  = r_m_last;
    assign m_axis_tuser  = r_m_user;
    assign drop_bad_cnt  = r_drop_bad;
    assign drop_ovf_cnt  = r_drop_ovf;
    assign fifo_level    = r_wr_commit - r_rd_ptr;

endmodule
